// File: rtl/gantry_move_ctrl.sv
// gantry_move_ctrl: runs one relative gantry move at a time.
// It settles the magnet, steps X and then Y, and tracks the absolute position.
//
// Ports:
//   clock, reset (async, active-low)
//   cmd_valid/cmd_ready : command handshake
//   cmd_dx, cmd_dy      : signed step deltas
//   cmd_magnet          : magnet state for the move
//   step_x/dir_x        : X stepper pins
//   step_y/dir_y        : Y stepper pins
//   magnet              : electromagnet enable
//   busy, done          : move status; done pulses for one cycle
//   pos_x, pos_y        : signed absolute position, wraps modulo 2^POS_W
module gantry_move_ctrl #(
    parameter int DELTA_W       = 8,
    parameter int POS_W         = 12,
    parameter int HALF_PERIOD   = 25000,
    parameter int SETTLE_CYCLES = 500000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [DELTA_W-1:0] cmd_dx,
    input  logic [DELTA_W-1:0] cmd_dy,
    input  logic               cmd_magnet,
    output logic               step_x,
    output logic               dir_x,
    output logic               step_y,
    output logic               dir_y,
    output logic               magnet,
    output logic               busy,
    output logic               done,
    output logic [POS_W-1:0]   pos_x,
    output logic [POS_W-1:0]   pos_y
);

    localparam int CNT_MAX = (HALF_PERIOD > SETTLE_CYCLES) ?
                             HALF_PERIOD : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] HP_LAST     = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        STEP_X,
        STEP_Y,
        DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [DELTA_W-1:0] mag_x;
    logic [DELTA_W-1:0] mag_y;
    logic [DELTA_W-1:0] steps_left;

    logic hp_last;
    logic settle_last;

    // Unsigned magnitude; the most negative delta maps to 2^(DELTA_W-1),
    // which still fits in DELTA_W unsigned bits.
    function automatic logic [DELTA_W-1:0] magnitude(
        input logic [DELTA_W-1:0] d
    );
        return d[DELTA_W-1] ? (~d + DELTA_W'(1)) : d;
    endfunction

    assign hp_last     = (cnt == HP_LAST);
    assign settle_last = (cnt == SETTLE_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            mag_x      <= '0;
            mag_y      <= '0;
            steps_left <= '0;
            cmd_ready  <= 1'b1;
            step_x     <= 1'b0;
            dir_x      <= 1'b0;
            step_y     <= 1'b0;
            dir_y      <= 1'b0;
            magnet     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pos_x      <= '0;
            pos_y      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        mag_x     <= magnitude(cmd_dx);
                        mag_y     <= magnitude(cmd_dy);
                        dir_x     <= ~cmd_dx[DELTA_W-1];
                        dir_y     <= ~cmd_dy[DELTA_W-1];
                        magnet    <= cmd_magnet;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        cnt       <= '0;
                        state     <= SETTLE;
                    end
                end

                SETTLE: begin
                    if (!settle_last) begin
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        cnt <= '0;
                        if (mag_x != '0) begin
                            state      <= STEP_X;
                            step_x     <= 1'b1;
                            steps_left <= mag_x;
                        end else if (mag_y != '0) begin
                            state      <= STEP_Y;
                            step_y     <= 1'b1;
                            steps_left <= mag_y;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end

                // step_x itself marks the high or low half of the pulse.
                // Position moves on the high-to-low edge.
                STEP_X: begin
                    if (!hp_last) begin
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        cnt <= '0;
                        if (step_x) begin
                            step_x     <= 1'b0;
                            steps_left <= steps_left - DELTA_W'(1);
                            pos_x      <= dir_x ? pos_x + POS_W'(1)
                                                : pos_x - POS_W'(1);
                        end else if (steps_left != '0) begin
                            step_x <= 1'b1;
                        end else if (mag_y != '0) begin
                            state      <= STEP_Y;
                            step_y     <= 1'b1;
                            steps_left <= mag_y;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end

                STEP_Y: begin
                    if (!hp_last) begin
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        cnt <= '0;
                        if (step_y) begin
                            step_y     <= 1'b0;
                            steps_left <= steps_left - DELTA_W'(1);
                            pos_y      <= dir_y ? pos_y + POS_W'(1)
                                                : pos_y - POS_W'(1);
                        end else if (steps_left != '0) begin
                            step_y <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end

                // The done pulse is already showing; busy stays up through it.
                DONE: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end

                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    step_x    <= 1'b0;
                    step_y    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/gantry_move_ctrl.md
Name: gantry_move_ctrl

Overview:
- Sequences the board gantry: accepts one relative move command (X delta, Y delta, magnet state) from the processor's memory-mapped peripheral logic in Wrapper.
- Drives the step/dir pins for two stepper axes and the piece-lifting electromagnet.
- Tracks the absolute gantry position.
- Outputs map to JA_1..JA_4 (step_x, dir_x, step_y, dir_y) plus a magnet enable. busy/done/position are readable by software.

Parameters:
- DELTA_W, 8, width of signed two's-complement move deltas.
- POS_W, 12, width of signed position counters.
- HALF_PERIOD, 25000, clock cycles step output stays high, and then low, per step (≥1).
- SETTLE_CYCLES, 500000, cycles waited after magnet update before first step (≥1).

Ports:
- clock, input, 1, system clock (rising edge).
- reset, input, 1, asynchronous active-low reset (0 = reset).
- cmd_valid, input, 1, command present.
- cmd_ready, output, 1, controller can accept a command.
- cmd_dx, input, DELTA_W, signed X delta in steps.
- cmd_dy, input, DELTA_W, signed Y delta in steps.
- cmd_magnet, input, 1, magnet state for this move.
- step_x, output, 1, X step pulse.
- dir_x, output, 1, X direction (1 = +).
- step_y, output, 1, Y step pulse.
- dir_y, output, 1, Y direction (1 = +).
- magnet, output, 1, electromagnet enable.
- busy, output, 1, move in progress.
- done, output, 1, one-cycle completion pulse.
- pos_x, output, POS_W, signed absolute X position.
- pos_y, output, POS_W, signed absolute Y position.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0 except cmd_ready=1.
  - pos_x = pos_y = 0; state IDLE; internal counters 0.
  - Asserting reset mid-move aborts immediately; no further step edges occur.
- States: IDLE, SETTLE, STEP_X, STEP_Y, DONE.
- IDLE:
  - cmd_ready=1, busy=0.
  - Handshake when cmd_valid & cmd_ready at a rising edge. At that edge:
    - latch |cmd_dx| and |cmd_dy| as DELTA_W-bit unsigned magnitudes (-2^(DELTA_W-1) gives 2^(DELTA_W-1));
    - dir_x <= (cmd_dx ≥ 0); dir_y <= (cmd_dy ≥ 0); magnet <= cmd_magnet;
    - go to SETTLE.
- Outside IDLE:
  - cmd_ready=0 and busy=1; cmd_valid is ignored and no command is latched.
  - dir_x, dir_y and magnet hold their values until the next handshake. magnet remains asserted after done.
- SETTLE: exactly SETTLE_CYCLES cycles, then STEP_X if |dx|≠0, else STEP_Y if |dy|≠0, else DONE.
- STEP_X:
  - Each step is step_x=1 for HALF_PERIOD cycles, then step_x=0 for HALF_PERIOD cycles.
  - pos_x is incremented if dir_x=1, else decremented, on the falling step edge (the high→low transition cycle).
  - After |dx| steps, go to STEP_Y if |dy|≠0, else DONE.
  - Total phase length is 2·HALF_PERIOD·|dx| cycles.
- STEP_Y: identical using step_y, dir_y, pos_y, |dy|; then DONE.
- X and Y never step in the same cycle.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE (cmd_ready=1 the following cycle).
- Position arithmetic: two's complement modulo 2^POS_W; wraps silently, with no saturation.
- Step outputs are registered; no combinational path from cmd_* to any output.
- Latency from handshake edge (cycle 0):
  - SETTLE occupies cycles 1..SETTLE_CYCLES;
  - done is high in cycle 1 + SETTLE_CYCLES + 2·HALF_PERIOD·(|dx|+|dy|).

Test Plan (HALF_PERIOD=2, SETTLE_CYCLES=3, DELTA_W=8, POS_W=12):
- Reset:
  - hold reset=0 for 3 cycles, release → cmd_ready=1 and all other outputs 0, pos=(0,0).
- Simple X move, handshake at cycle 0 with dx=+3, dy=0, magnet=1:
  - dir_x=1 and magnet=1 from cycle 1;
  - step_x high in cycles 4-5, 8-9, 12-13;
  - done in cycle 16; cmd_ready=1 in cycle 17; pos_x=3, pos_y=0.
- Mixed move, from pos (3,0) with dx=-2, dy=+1, magnet=0:
  - dir_x=0, dir_y=1, magnet=0;
  - two step_x pulses, then one step_y pulse starting exactly one cycle after the last X low phase;
  - no overlap between axes; done in cycle 16; pos=(1,1).
- Zero move, dx=0, dy=0:
  - no step pulses; done in cycle 4; pos unchanged.
- Extreme negative delta, dx=-128:
  - exactly 128 step_x pulses with dir_x=0; pos_x decreases by 128; done in cycle 516.
- Busy and reset behaviour:
  - pulse cmd_valid with dx=+5 during STEP_X → ignored, and pos reflects only the first command.
  - assert reset=0 mid-STEP_X → outputs zero asynchronously, pos=(0,0), cmd_ready=1 after release.
